// File: rtl/apb_slave_regfile_if.sv
`default_nettype none
// ============================================================
// Module   : apb_slave_regfile_if
// Brief    : APB bus bundle between a requester and the register file.
// Revision : 1.0
// ============================================================
interface apb_slave_regfile_if;
    logic [2:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;
    logic        Pready;
    logic        Pslverr;

    modport master (
        output Pselx, Penable, Pwrite, Paddr, Pwdata,
        input  Prdata, Pready, Pslverr
    );

    modport slave (
        input  Pselx, Penable, Pwrite, Paddr, Pwdata,
        output Prdata, Pready, Pslverr
    );
endinterface
`default_nettype wire

// File: rtl/apb_slave_regfile.sv
`default_nettype none
// ============================================================
// Module   : apb_slave_regfile
// Brief    : APB completer with six R/W registers, a transfer counter,
//            an ID register and a programmable number of wait states.
// Revision : 1.0
// ============================================================
module apb_slave_regfile #(
    parameter int SLAVE_ID    = 0,
    parameter int WAIT_STATES = 0
) (
    input  wire                Hclk,
    input  wire                Hresetn,
    apb_slave_regfile_if.slave bus
);
    localparam logic [3:0]  c_wait = 4'(WAIT_STATES);
    localparam logic [31:0] c_id   = 32'h5A5A_0000 | 32'(SLAVE_ID);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_wcnt;
    logic [3:0]  w_wcnt_nxt;
    logic        w_latch;
    logic [7:0]  r_addr;
    logic        r_write;
    logic [31:0] r_regs [0:5];
    logic [15:0] r_xcnt;
    logic        w_sel;
    logic        w_pready;
    logic        w_err;
    logic [2:0]  w_idx;
    logic [31:0] w_rdval;
    logic        w_unused;

    assign w_sel    = bus.Pselx[SLAVE_ID];
    assign w_unused = ^{bus.Paddr[31:8], bus.Pselx};
    assign w_idx    = r_addr[4:2];

    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        w_latch     = 1'b0;
        case (r_state)
            IDLE: begin
                // Only a proper setup phase opens a transfer.
                if (w_sel && !bus.Penable) begin
                    w_state_nxt = ACCESS;
                    w_wcnt_nxt  = c_wait;
                    w_latch     = 1'b1;
                end
            end
            ACCESS: begin
                if (w_sel && bus.Penable) begin
                    if (r_wcnt != 4'd0) begin
                        w_wcnt_nxt = r_wcnt - 4'd1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Gated by Hresetn so the outputs stay quiet while reset is held.
    assign w_pready = Hresetn && (r_state == ACCESS) && (r_wcnt == 4'd0)
                      && w_sel && bus.Penable;

    assign w_err = (r_addr[7:5] != 3'd0) || (r_addr[1:0] != 2'd0)
                   || (r_write && w_idx[2] && w_idx[1]);

    always_comb begin
        w_rdval = 32'h0;
        case (w_idx)
            3'd6:    w_rdval = {16'h0, r_xcnt};
            3'd7:    w_rdval = c_id;
            default: w_rdval = r_regs[w_idx];
        endcase
    end

    assign bus.Pready  = w_pready;
    assign bus.Pslverr = w_pready && w_err;
    assign bus.Prdata  = (w_pready && !r_write && !w_err) ? w_rdval : 32'h0;

    always_ff @(posedge Hclk) begin
        if (!Hresetn) begin
            r_state <= IDLE;
            r_wcnt  <= 4'd0;
            r_addr  <= 8'h0;
            r_write <= 1'b0;
            r_xcnt  <= 16'h0;
            for (int i = 0; i < 6; i++) begin
                r_regs[i] <= 32'h0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
            if (w_latch) begin
                r_addr  <= bus.Paddr[7:0];
                r_write <= bus.Pwrite;
            end
            if (w_pready) begin
                r_xcnt <= r_xcnt + 16'd1;
            end
            // w_err already rejects writes to indices 6 and 7.
            if (w_pready && r_write && !w_err) begin
                r_regs[w_idx] <= bus.Pwdata;
            end
        end
    end
endmodule
`default_nettype wire

// File: doc/apb_slave_regfile.md
APB_SLAVE_REGFILE -- requirements
Module: apb_slave_regfile

Interface
REQ-001 Parameter SLAVE_ID, default 0, meaning the index (0..2) of the Pselx bit this completer responds to.
REQ-002 Parameter WAIT_STATES, default 0, meaning the extra access cycles (0..15) inserted before Pready.
REQ-003 Hclk  input  1  the single clock; all state updates on the rising edge.
REQ-004 Hresetn  input  1  reset, synchronous and active-low.
REQ-005 Pselx  input  3  one-hot slave selects; only Pselx[SLAVE_ID] is used.
REQ-006 Penable  input  1  APB access-phase strobe.
REQ-007 Pwrite  input  1  1 = write, 0 = read.
REQ-008 Paddr  input  32  byte address; Paddr[7:0] is the offset within this slave.
REQ-009 Pwdata  input  32  write data.
REQ-010 Prdata  output  32  read data.
REQ-011 Pready  output  1  transfer-complete strobe.
REQ-012 Pslverr  output  1  error response, valid only while Pready=1.

Function
REQ-013 sel = Pselx[SLAVE_ID]; other Pselx bits SHALL be ignored.
REQ-014 FSM states: IDLE, ACCESS.
REQ-015 IDLE->ACCESS when sel=1 and Penable=0 (setup phase).
- Paddr and Pwrite are latched at this edge.
- Wait counter is loaded with WAIT_STATES.
REQ-016 In IDLE, sel=1 with Penable=1 (no prior setup) SHALL be ignored: stay IDLE, no write, Pready=0.
REQ-017 In ACCESS with sel=1 and Penable=1, a nonzero counter SHALL decrement by 1 per cycle.
REQ-018 Pready = (state==ACCESS) & (counter==0) & sel & Penable, decoded from registered state; zero-wait transfer = 2 cycles (setup + 1 access); N waits = 2+N cycles.
REQ-019 The cycle after Pready=1, the FSM SHALL return to IDLE; a new setup phase in that cycle SHALL be accepted normally (back-to-back, no dead cycle beyond APB setup).
REQ-020 In ACCESS, sel=0 or Penable=0 before completion SHALL abort to IDLE with no register update and no counter increment.
REQ-021 Register map, word index = latched Paddr[4:2]:
- 0-5: R/W 32-bit general registers.
- 6: RO transfer counter, zero-extended 16 bits.
- 7: RO ID = 32'h5A5A_0000 | SLAVE_ID.
REQ-022 Error condition (Pslverr=1 with Pready) for any of:
- latched Paddr[7:5]!=0;
- latched Paddr[1:0]!=0;
- write to index 6 or 7.
REQ-023 Write commits Pwdata (sampled in the Pready cycle) to the register at the edge ending the Pready cycle, only if no error.
REQ-024 Prdata = selected register when Pready=1, Pwrite=0 and no error; otherwise 32'h0.
REQ-025 Transfer counter SHALL increment by 1 on every completed transfer (Pready=1), error or not; it wraps 16'hFFFF->16'h0000.
REQ-026 Pwrite and Paddr changes during ACCESS SHALL be ignored; latched values govern the transfer.

Reset
REQ-027 Hresetn=0 at a rising edge SHALL force: state IDLE, counter 0, registers 0-5 = 0, transfer counter 0.
REQ-028 While in reset and in the cycle after, Pready=0, Pslverr=0, Prdata=0.
REQ-029 Reset during ACCESS SHALL abort the transfer with no register write.

Verification
REQ-030 Zero-wait write then read:
- Write 32'hDEADBEEF to offset 0x08.
- Read offset 0x08 -> Pready in 2nd cycle of each transfer, Prdata=32'hDEADBEEF, Pslverr=0.
REQ-031 WAIT_STATES=3, read offset 0x1C with SLAVE_ID=2 on Pselx=3'b100:
- Pready high in 5th cycle only.
- Prdata=32'h5A5A0002.
REQ-032 Error cases:
- Write offset 0x1C -> Pslverr=1 with Pready; readback unchanged.
- Read offset 0x40 -> Pslverr=1, Prdata=0.
- Read offset 0x02 -> Pslverr=1, Prdata=0.
REQ-033 Protocol violations:
- Penable=1 without setup -> no Pready.
- sel dropped mid-wait -> abort to IDLE, register unchanged.
- Pselx=3'b010 with SLAVE_ID=0 -> no response.
REQ-034 Transfer counter:
- Reset, then 3 transfers; read offset 0x18 -> 32'h0000_0003 (count excludes that read).
- Preload via 65535 transfers -> wraps to 0.
REQ-035 Reset mid-operation:
- Assert Hresetn=0 during ACCESS of a write of 32'h1234 to offset 0x00.
- Read offset 0x00 after reset -> 32'h0; outputs 0 during reset.
